// File: rtl/rtype_instr_writer_if.sv
// ============================================================================
// rtype_instr_writer_if : request, memory-write and status signals of the
//                         R-type instruction writer.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface rtype_instr_writer_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [4:0]        req_rs;
    logic [4:0]        req_rt;
    logic [4:0]        req_rd;
    logic [4:0]        req_shamt;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W-1:0] words_written;
    logic              err_illegal;
    logic              addr_wrap;

    // Request issuer / memory side.
    modport master (
        output req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, wr_ready,
        input  req_ready, wr_valid, wr_addr, wr_data, words_written,
               err_illegal, addr_wrap
    );

    // Writer block.
    modport slave (
        input  req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, wr_ready,
        output req_ready, wr_valid, wr_addr, wr_data, words_written,
               err_illegal, addr_wrap
    );
endinterface

`default_nettype wire

// File: rtl/rtype_instr_writer.sv
// ============================================================================
// rtype_instr_writer : encodes ALU requests into MIPS R-type words, buffers
//                      them in a FIFO and writes them to instruction memory.
// Optional macro: SHAMT_CHECK_EN (non-shift op with shamt != 0 is illegal).
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rtype_instr_writer #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    rtype_instr_writer_if.slave    bus
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [5:0]  w_funct;
    logic        w_legal;
    logic        w_is_shift;
    logic [4:0]  w_shamt_eff;
    logic [31:0] w_word;

    always_comb begin
        w_funct = 6'h00;
        w_legal = 1'b1;
        unique case (bus.req_op)
            4'd0:    w_funct = 6'h20;
            4'd1:    w_funct = 6'h22;
            4'd2:    w_funct = 6'h24;
            4'd3:    w_funct = 6'h25;
            4'd4:    w_funct = 6'h26;
            4'd5:    w_funct = 6'h27;
            4'd6:    w_funct = 6'h2A;
            4'd7:    w_funct = 6'h00;
            4'd8:    w_funct = 6'h02;
            default: w_legal = 1'b0;
        endcase

        w_is_shift  = (bus.req_op == 4'd7) || (bus.req_op == 4'd8);
        w_shamt_eff = w_is_shift ? bus.req_shamt : 5'd0;

`ifdef SHAMT_CHECK_EN
        if (!w_is_shift && (bus.req_shamt != 5'd0)) begin
            w_legal = 1'b0;
        end
`endif

        w_word = {6'b0, bus.req_rs, bus.req_rt, bus.req_rd, w_shamt_eff, w_funct};
    end

    // ------------------------------------------------------------------
    // FIFO and write-side state
    // ------------------------------------------------------------------
    logic [31:0]        mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q,  count_d;
    logic [ADDR_W-1:0]  addr_q,   addr_d;
    logic [ADDR_W-1:0]  written_q, written_d;
    logic               err_q,    err_d;
    logic               wrap_q,   wrap_d;

    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W:0]    w_addr_sum;

    // Ready looks only at registered occupancy, so a full FIFO blocks a
    // push even in a cycle where the head is being written out.
    assign w_full   = (count_q == c_CNT_W'(DEPTH));
    assign w_empty  = (count_q == '0);
    assign w_accept = bus.req_valid && !w_full;
    assign w_push   = w_accept && w_legal;
    assign w_pop    = !w_empty && bus.wr_ready;

    assign w_addr_sum = {1'b0, addr_q} + (ADDR_W+1)'(4);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        addr_d    = addr_q;
        written_d = written_q;
        err_d     = err_q;
        wrap_d    = wrap_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_accept && !w_legal) begin
            err_d = 1'b1;
        end

        if (w_pop) begin
            rd_ptr_d  = rd_ptr_q + c_PTR_W'(1);
            addr_d    = w_addr_sum[ADDR_W-1:0];
            written_d = written_q + ADDR_W'(1);
            if (w_addr_sum[ADDR_W]) begin
                wrap_d = 1'b1;
            end
        end

        unique case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            addr_q    <= ADDR_W'(BASE_ADDR);
            written_q <= '0;
            err_q     <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            written_q <= written_d;
            err_q     <= err_d;
            wrap_q    <= wrap_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_word;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready     = !w_full;
    assign bus.wr_valid      = !w_empty;
    assign bus.wr_data       = w_empty ? 32'h0 : mem_q[rd_ptr_q];
    assign bus.wr_addr       = addr_q;
    assign bus.words_written = written_q;
    assign bus.err_illegal   = err_q;
    assign bus.addr_wrap     = wrap_q;

endmodule

`default_nettype wire

// File: doc/rtype_instr_writer.md
Name: rtype_instr_writer

Overview:
Producer side of the R-type function-code path. Accepts abstract ALU operation requests with register/shift fields and encodes each into a 32-bit MIPS R-type instruction word (opcode 0, funct field per operation). Buffers the words in a small FIFO and writes them sequentially into instruction memory. The instruction memory feeds the fetch/decode path that converts funct codes into ALU select bits.

Parameters:
ADDR_W, 8, instruction-memory byte-address width.
BASE_ADDR, 0, first write address; must be a multiple of 4.
DEPTH, 4, FIFO depth in words; must be a power of 2 and at least 2.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  a request is present.
req_ready  output  1  block can accept a request.
req_op  input  4  operation code (table below).
req_rs  input  5  rs field.
req_rt  input  5  rt field.
req_rd  input  5  rd field.
req_shamt  input  5  shift amount.
wr_valid  output  1  a memory write is pending.
wr_ready  input  1  memory accepts the write.
wr_addr  output  ADDR_W  byte address of the write.
wr_data  output  32  encoded instruction word.
words_written  output  ADDR_W  count of completed writes, modulo 2^ADDR_W.
err_illegal  output  1  sticky flag: a request was dropped.
addr_wrap  output  1  sticky flag: the write address wrapped.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: FIFO empty, wr_valid=0, wr_addr=BASE_ADDR, wr_data=0, words_written=0, err_illegal=0, addr_wrap=0, req_ready=1.
- Asserting rst_n low mid-operation immediately discards all buffered words, including any pending write.
- Operation encoding (req_op to funct):
  - 0 ADD 0x20; 1 SUB 0x22; 2 AND 0x24; 3 OR 0x25; 4 XOR 0x26; 5 NOR 0x27; 6 SLT 0x2A; 7 SLL 0x00; 8 SRL 0x02.
  - Ops 9 to 15 are illegal.
- Instruction word: {6'b0, rs, rt, rd, shamt, funct}.
  - For non-shift ops (0 to 6), the shamt field is written as 0.
  - For SLL and SRL, req_rs is written as given.
- Request handshake: a request is accepted on a cycle with req_valid && req_ready.
  - req_ready = FIFO not full. It is registered-state based and does not depend on a same-cycle pop.
- Illegal request: accepted (consumes the handshake), not pushed, and sets err_illegal. err_illegal stays set until reset.
- Latency: a request accepted at edge N is visible on wr_valid/wr_data after edge N+1 (one-cycle minimum). There is no combinational bypass from the request inputs.
- Write handshake: wr_valid = FIFO not empty; wr_data = FIFO head.
  - A write completes on a cycle with wr_valid && wr_ready.
  - On completion: pop the FIFO, wr_addr += 4, words_written += 1.
  - While a write is pending, wr_addr/wr_data are held stable until it completes.
- Address wrap: wr_addr is computed modulo 2^ADDR_W. An increment that carries out sets addr_wrap, which is sticky until reset.
- Simultaneous push and pop:
  - When the FIFO is full, push is blocked (req_ready=0) even if a pop occurs that cycle.
  - At any other occupancy, push and pop both take effect and the count is unchanged.
- Order: words are written in request-acceptance order; none are dropped except illegal requests.

Optional Feature:
SHAMT_CHECK_EN
- Defined: a legal non-shift op with req_shamt != 0 is treated as illegal. It is dropped and sets err_illegal.
- Not defined: req_shamt is silently forced to 0 for non-shift ops and the request is written normally.

Test Plan:
- ADD rs=1 rt=2 rd=3 shamt=0, wr_ready=1 -> one write: wr_addr=0x00, wr_data=0x00221820 one cycle after acceptance; words_written=1.
- SRL rs=0 rt=5 rd=4 shamt=2 followed by OR rs=1 rt=2 rd=3 -> writes at 0x00 and 0x04 with data 0x00052082 and 0x00221825, in that order.
- req_op=15 -> no write; err_illegal=1 and stays 1 across later legal requests; req_ready never drops because of it.
- wr_ready=0, push 4 legal ops -> req_ready=0 after the 4th; a 5th request stalls. Raise wr_ready for one cycle while req_valid is held -> exactly one write completes; the 5th request is accepted only on the following cycle.
- ADDR_W=4, BASE_ADDR=0xC, two ADDs -> writes at 0xC then 0x0; addr_wrap=1; words_written=2.
- 3 words buffered, wr_valid=1, then pulse rst_n low asynchronously -> wr_valid=0, wr_addr=BASE_ADDR, all flags 0, with no clock edge needed; after release the FIFO is empty.
- SHAMT_CHECK_EN defined: ADD with shamt=3 -> dropped, err_illegal=1. Not defined: the same request writes 0x00221820.
